// File: rtl/exec_sequencer_pkg.sv
// Shared defs for the nano-cpu exec sequencer:
// FSM states, fault causes, instruction-class helpers.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_PC_OVF  = 2'd3;

  localparam logic [6:0] OPC_R = 7'h33;
  localparam logic [6:0] OPC_I = 7'h13;

  function automatic logic is_r_type(
    input logic [31:0] w
  );
    return w[6:0] == OPC_R;
  endfunction

  function automatic logic is_i_type(
    input logic [31:0] w
  );
    return w[6:0] == OPC_I;
  endfunction

  function automatic logic is_legal(
    input logic [31:0] w
  );
    return is_r_type(w) || is_i_type(w);
  endfunction

endpackage

// File: rtl/alu_watchdog.sv
// ALU watchdog: clearable up-counter, expired at TIMEOUT-1.
// Ports: clk, rst, clear, enable (count), expired.
module alu_watchdog
  import exec_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Saturates at LAST so a stalled
  // sequencer never wraps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/issue/retire FSM: owns PC, IR,
// ALU handshake, rf_we, halt, fault and retire count.
// Ports: clk, rst, imem_*, instr_legal, instruction,
// pc, alu_in_valid/out_valid, rf_we, halt_req,
// halted, fault, fault_cause, retired.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int IMEM_DEPTH  = 1024,
  parameter int ALU_TIMEOUT = 64,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          instr_legal,
  output logic [31:0]   instruction,
  output logic [31:0]   pc,
  output logic          alu_in_valid,
  input  logic          alu_out_valid,
  output logic          rf_we,
  input  logic          halt_req,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    fault_cause,
  output logic [31:0]   retired
);

  localparam logic [31:0] LAST_PC =
    32'(IMEM_DEPTH - 1);

  state_t state;
  logic   wd_clear;
  logic   wd_enable;
  logic   wd_expired;
  logic   last_word;

  assign imem_addr = pc[AW-1:0];
  assign last_word = (pc == LAST_PC);

  assign alu_in_valid =
    (state == S_ISSUE) && instr_legal;
  assign rf_we =
    (state == S_WAIT) && alu_out_valid;

  assign wd_clear  = (state == S_ISSUE);
  assign wd_enable =
    (state == S_WAIT) && !alu_out_valid;

  alu_watchdog #(
    .TIMEOUT (ALU_TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= '0;
      instruction <= '0;
      retired     <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      unique case (state)
        S_FETCH: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          instruction <= imem_rdata;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          if (instr_legal) begin
            state <= S_WAIT;
          end else begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_cause <= CAUSE_ILLEGAL;
          end
        end
        S_WAIT: begin
          // Completion takes priority over
          // a watchdog expiring this cycle.
          if (alu_out_valid) begin
            retired <= retired + 32'd1;
            if (last_word) begin
              state       <= S_FAULT;
              fault       <= 1'b1;
              fault_cause <= CAUSE_PC_OVF;
            end else begin
              pc <= pc + 32'd1;
              if (halt_req) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
          end else if (wd_expired) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end
        end
        S_HALT: begin
          if (!halt_req) begin
            state  <= S_FETCH;
            halted <= 1'b0;
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed testbench for exec_sequencer with a
// sync-read imem model and a fixed-latency ALU model.
module tb_exec_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_ADDI = 32'h00508093;
  localparam logic [31:0] W_SUB  = 32'h40208233;
  localparam logic [31:0] W_ILL  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_legal;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        alu_in_valid;
  logic        alu_out_valid;
  logic        rf_we;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] retired;

  logic [31:0] mem [DEPTH];
  int          errors = 0;
  int          checks = 0;

  int   k = 1;
  logic alu_en = 1'b1;
  logic force_ov = 1'b0;
  logic busy;
  int   cnt;

  int cyc;
  int we_cnt;
  int we_t [8];
  int iv_cnt;
  int iv_pc2;
  int both;

  always #5 clk = ~clk;

  exec_sequencer #(
    .IMEM_DEPTH  (DEPTH),
    .ALU_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_legal   (instr_legal),
    .instruction   (instruction),
    .pc            (pc),
    .alu_in_valid  (alu_in_valid),
    .alu_out_valid (alu_out_valid),
    .rf_we         (rf_we),
    .halt_req      (halt_req),
    .halted        (halted),
    .fault         (fault),
    .fault_cause   (fault_cause),
    .retired       (retired)
  );

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  assign instr_legal =
    (instruction[6:0] == 7'h33) ||
    (instruction[6:0] == 7'h13);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (alu_in_valid) begin
      busy <= 1'b1;
      cnt  <= 1;
    end else if (busy) begin
      if (alu_out_valid) busy <= 1'b0;
      cnt <= cnt + 1;
    end
  end

  assign alu_out_valid =
    (busy && cnt == k && alu_en) || force_ov;

  // Cycle 1 is the cycle in which rst falls.
  always @(negedge clk) begin
    if (rst) begin
      cyc    <= 0;
      we_cnt <= 0;
      iv_cnt <= 0;
      iv_pc2 <= 0;
    end else begin
      cyc <= cyc + 1;
      if (rf_we) begin
        if (we_cnt < 8) we_t[we_cnt] <= cyc + 1;
        we_cnt <= we_cnt + 1;
      end
      if (alu_in_valid) begin
        iv_cnt <= iv_cnt + 1;
        if (pc == 32'd2) iv_pc2 <= iv_pc2 + 1;
      end
    end
  end

  initial both = 0;
  always @(negedge clk)
    if (alu_in_valid && rf_we) both <= both + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    halt_req = 1'b0;
    force_ov = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  task automatic wait_fault(
    input int lim, output bit ok
  );
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      run(1);
      if (fault) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run(2);
    checks += 9;
    if (pc !== 32'd0) begin
      errors++;
      $display("FAIL rst_pc got=%0d exp=0", pc);
    end
    if (instruction !== 32'd0) begin
      errors++;
      $display("FAIL rst_ir got=%h exp=0",
               instruction);
    end
    if (retired !== 32'd0) begin
      errors++;
      $display("FAIL rst_ret got=%0d exp=0",
               retired);
    end
    if (alu_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_iv got=%b exp=0",
               alu_in_valid);
    end
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_we got=%b exp=0", rf_we);
    end
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_halt got=%b exp=0",
               halted);
    end
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_fault got=%b exp=0",
               fault);
    end
    if (fault_cause !== 2'd0) begin
      errors++;
      $display("FAIL rst_cause got=%0d exp=0",
               fault_cause);
    end
    if (imem_addr !== 2'd0) begin
      errors++;
      $display("FAIL rst_addr got=%0d exp=0",
               imem_addr);
    end
  endtask

  task automatic test_latency(
    input int kk, input int t0,
    input int t1, input int t2
  );
    bit ok;
    mem[0] = W_ADD;
    mem[1] = W_ADDI;
    mem[2] = W_SUB;
    mem[3] = W_ILL;
    k = kk;
    alu_en = 1'b1;
    do_reset();
    wait_fault(100, ok);
    checks += 7;
    if (!ok) begin
      errors++;
      $display("FAIL lat%0d_done no fault seen",
               kk);
    end
    if (we_cnt !== 3) begin
      errors++;
      $display("FAIL lat%0d_we_cnt got=%0d exp=3",
               kk, we_cnt);
    end
    if (we_t[0] !== t0 || we_t[1] !== t1 ||
        we_t[2] !== t2) begin
      errors++;
      $display("FAIL lat%0d_we_t got=%0d,%0d,%0d exp=%0d,%0d,%0d",
               kk, we_t[0], we_t[1], we_t[2],
               t0, t1, t2);
    end
    if (retired !== 32'd3) begin
      errors++;
      $display("FAIL lat%0d_ret got=%0d exp=3",
               kk, retired);
    end
    if (pc !== 32'd3) begin
      errors++;
      $display("FAIL lat%0d_pc got=%0d exp=3",
               kk, pc);
    end
    if (fault_cause !== 2'd1) begin
      errors++;
      $display("FAIL lat%0d_cause got=%0d exp=1",
               kk, fault_cause);
    end
    if (iv_cnt !== 3) begin
      errors++;
      $display("FAIL lat%0d_iv got=%0d exp=3",
               kk, iv_cnt);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    mem[0] = W_ADD;
    mem[1] = W_ADDI;
    mem[2] = W_ILL;
    mem[3] = W_ADD;
    k = 2;
    alu_en = 1'b1;
    do_reset();
    wait_fault(60, ok);
    checks += 8;
    if (!ok) begin
      errors++;
      $display("FAIL ill_fault got=0 exp=1");
    end
    if (fault_cause !== 2'd1) begin
      errors++;
      $display("FAIL ill_cause got=%0d exp=1",
               fault_cause);
    end
    if (retired !== 32'd2) begin
      errors++;
      $display("FAIL ill_ret got=%0d exp=2",
               retired);
    end
    if (pc !== 32'd2) begin
      errors++;
      $display("FAIL ill_pc got=%0d exp=2", pc);
    end
    if (instruction !== W_ILL) begin
      errors++;
      $display("FAIL ill_ir got=%h exp=%h",
               instruction, W_ILL);
    end
    if (iv_pc2 !== 0) begin
      errors++;
      $display("FAIL ill_iv_w2 got=%0d exp=0",
               iv_pc2);
    end
    if (iv_cnt !== 2) begin
      errors++;
      $display("FAIL ill_iv got=%0d exp=2",
               iv_cnt);
    end
    run(4);
    if (fault !== 1'b1 || pc !== 32'd2) begin
      errors++;
      $display("FAIL ill_sticky fault=%b pc=%0d exp=1,2",
               fault, pc);
    end
  endtask

  task automatic test_timeout();
    mem[0] = W_ADD;
    mem[1] = W_ADD;
    mem[2] = W_ADD;
    mem[3] = W_ADD;
    k = 1;
    alu_en = 1'b0;
    do_reset();
    run(10);
    checks += 2;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early got=%b exp=0",
               fault);
    end
    if (iv_cnt !== 1) begin
      errors++;
      $display("FAIL tmo_iv got=%0d exp=1",
               iv_cnt);
    end
    run(1);
    checks += 3;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fault got=%b exp=1",
               fault);
    end
    if (fault_cause !== 2'd2) begin
      errors++;
      $display("FAIL tmo_cause got=%0d exp=2",
               fault_cause);
    end
    if (pc !== 32'd0) begin
      errors++;
      $display("FAIL tmo_pc got=%0d exp=0", pc);
    end
    force_ov = 1'b1;
    #1;
    checks += 1;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL tmo_late_we got=%b exp=0",
               rf_we);
    end
    run(2);
    checks += 1;
    if (we_cnt !== 0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL tmo_late_ret we=%0d ret=%0d exp=0,0",
               we_cnt, retired);
    end
    force_ov = 1'b0;
    alu_en = 1'b1;
  endtask

  task automatic test_halt();
    mem[0] = W_ADD;
    mem[1] = W_ADDI;
    mem[2] = W_SUB;
    mem[3] = W_ADD;
    k = 3;
    alu_en = 1'b1;
    do_reset();
    run(9);
    checks += 1;
    if (pc !== 32'd1) begin
      errors++;
      $display("FAIL hlt_pre_pc got=%0d exp=1", pc);
    end
    halt_req = 1'b1;
    run(3);
    checks += 3;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL hlt_halted got=%b exp=1",
               halted);
    end
    if (pc !== 32'd2) begin
      errors++;
      $display("FAIL hlt_pc got=%0d exp=2", pc);
    end
    if (retired !== 32'd2) begin
      errors++;
      $display("FAIL hlt_ret got=%0d exp=2",
               retired);
    end
    run(3);
    checks += 1;
    if (halted !== 1'b1 || iv_cnt !== 2) begin
      errors++;
      $display("FAIL hlt_hold halted=%b iv=%0d exp=1,2",
               halted, iv_cnt);
    end
    halt_req = 1'b0;
    run(1);
    checks += 2;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL hlt_resume got=%b exp=0",
               halted);
    end
    if (imem_addr !== 2'd2) begin
      errors++;
      $display("FAIL hlt_addr got=%0d exp=2",
               imem_addr);
    end
    run(2);
    checks += 1;
    if (instruction !== W_SUB) begin
      errors++;
      $display("FAIL hlt_ir got=%h exp=%h",
               instruction, W_SUB);
    end
  endtask

  task automatic test_overflow();
    mem[0] = W_ADD;
    mem[1] = W_ADDI;
    mem[2] = W_SUB;
    mem[3] = W_ADDI;
    k = 1;
    alu_en = 1'b1;
    do_reset();
    run(13);
    halt_req = 1'b1;
    run(3);
    checks += 5;
    if (fault !== 1'b1 || fault_cause !== 2'd3) begin
      errors++;
      $display("FAIL ovf_cause fault=%b cause=%0d exp=1,3",
               fault, fault_cause);
    end
    if (pc !== 32'd3) begin
      errors++;
      $display("FAIL ovf_pc got=%0d exp=3", pc);
    end
    if (retired !== 32'd4) begin
      errors++;
      $display("FAIL ovf_ret got=%0d exp=4",
               retired);
    end
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL ovf_halt got=%b exp=0",
               halted);
    end
    if (we_cnt !== 4) begin
      errors++;
      $display("FAIL ovf_we got=%0d exp=4",
               we_cnt);
    end
    halt_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem[0] = W_ADDI;
    mem[1] = W_ADD;
    mem[2] = W_SUB;
    mem[3] = W_ADD;
    k = 5;
    alu_en = 1'b1;
    do_reset();
    run(13);
    checks += 1;
    if (pc !== 32'd1 || retired !== 32'd1) begin
      errors++;
      $display("FAIL rmid_pre pc=%0d ret=%0d exp=1,1",
               pc, retired);
    end
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (pc !== 32'd0 || retired !== 32'd0 ||
        instruction !== 32'd0) begin
      errors++;
      $display("FAIL rmid_regs pc=%0d ret=%0d ir=%h exp=0",
               pc, retired, instruction);
    end
    if (alu_in_valid !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL rmid_strobes iv=%b we=%b exp=0,0",
               alu_in_valid, rf_we);
    end
    if (imem_addr !== 2'd0 || fault !== 1'b0 ||
        halted !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ctl addr=%0d f=%b h=%b exp=0",
               imem_addr, fault, halted);
    end
    run(1);
    rst = 1'b0;
    run(2);
    checks += 2;
    if (instruction !== W_ADDI) begin
      errors++;
      $display("FAIL rmid_refetch got=%h exp=%h",
               instruction, W_ADDI);
    end
    if (we_cnt !== 0) begin
      errors++;
      $display("FAIL rmid_stale_we got=%0d exp=0",
               we_cnt);
    end
    run(5);
    checks += 1;
    if (rf_we !== 1'b1) begin
      errors++;
      $display("FAIL rmid_we got=%b exp=1", rf_we);
    end
    run(1);
    checks += 1;
    if (pc !== 32'd1 || retired !== 32'd1) begin
      errors++;
      $display("FAIL rmid_post pc=%0d ret=%0d exp=1,1",
               pc, retired);
    end
  endtask

  initial begin
    test_reset();
    test_latency(1, 4, 8, 12);
    test_latency(5, 8, 16, 24);
    test_illegal();
    test_timeout();
    test_halt();
    test_overflow();
    test_reset_mid();
    checks += 1;
    if (both !== 0) begin
      errors++;
      $display("FAIL iv_we_overlap got=%0d exp=0",
               both);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
